// File: rtl/lsu_pkg.sv
// lsu_pkg: shared widths and FSM state encoding for the load/store unit.
// Width constants are also used by the register file.
package lsu_pkg;

  localparam int BITS  = 8;
  localparam int RBITS = 3;
  localparam int ABITS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WB     = 2'd2
  } state_e;

endpackage

// File: rtl/lsu_timer.sv
// lsu_timer: bus wait counter for the load/store unit.
// tc flags the enabled cycle whose increment reaches TIMEOUT.
module lsu_timer #(
  parameter int TIMEOUT = 15,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          ld,
  input  logic [CW-1:0] ld_val,
  input  logic          en,
  output logic          tc
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc = en && (cnt_q == CW'(TIMEOUT - 1));

  // next count: clear beats load beats increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (ld) begin
      cnt_d = ld_val;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit for the 8-bit core.
// One req/ack bus access at a time; loads write back via wb_*.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             start,
  input  logic             is_store,
  input  logic [BITS-1:0]  base,
  input  logic [BITS-1:0]  offset,
  input  logic [BITS-1:0]  store_data,
  input  logic [RBITS-1:0] dest,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic             mem_req,
  output logic             mem_we,
  output logic [ABITS-1:0] mem_addr,
  output logic [BITS-1:0]  mem_wdata,
  input  logic             mem_ack,
  input  logic [BITS-1:0]  mem_rdata,
  output logic             wb_we,
  output logic [RBITS-1:0] wb_rd,
  output logic [BITS-1:0]  wb_din
);

  localparam int CW = 8;

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [BITS-1:0]  wdata_q, wdata_d;
  logic             wb_we_q, wb_we_d;
  logic [RBITS-1:0] wb_rd_q, wb_rd_d;
  logic [BITS-1:0]  wb_din_q, wb_din_d;
  logic             st_q, st_d;
  logic [RBITS-1:0] dest_q, dest_d;

  logic [BITS-1:0]  sum;
  logic             tmr_clr;
  logic             tmr_en;
  logic             tmr_tc;

  // address wraps modulo 2^BITS, then zero-extends onto the bus
  assign sum    = base + offset;
  assign tmr_en = run && (state_q == ACCESS);

  lsu_timer #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .ld     (1'b0),
    .ld_val ('0),
    .en     (tmr_en),
    .tc     (tmr_tc)
  );

  // FSM next state and registered outputs; run low holds everything
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = done_q;
    fault_d  = fault_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wb_we_d  = wb_we_q;
    wb_rd_d  = wb_rd_q;
    wb_din_d = wb_din_q;
    st_d     = st_q;
    dest_d   = dest_q;
    tmr_clr  = 1'b0;
    if (run) begin
      unique case (state_q)
        IDLE: begin
          done_d = 1'b0;
          if (start) begin
            addr_d  = ABITS'(sum);
            wdata_d = store_data;
            we_d    = is_store;
            st_d    = is_store;
            dest_d  = dest;
            req_d   = 1'b1;
            fault_d = 1'b0;
            tmr_clr = 1'b1;
            busy_d  = 1'b1;
            state_d = ACCESS;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            req_d  = 1'b0;
            we_d   = 1'b0;
            done_d = 1'b1;
            if (st_q) begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              wb_din_d = mem_rdata;
              wb_rd_d  = dest_q;
              wb_we_d  = |dest_q;
              state_d  = WB;
            end
          end else if (tmr_tc) begin
            req_d   = 1'b0;
            we_d    = 1'b0;
            fault_d = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
        WB: begin
          wb_we_d = 1'b0;
          done_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wb_we_q  <= 1'b0;
      wb_rd_q  <= '0;
      wb_din_q <= '0;
      st_q     <= 1'b0;
      dest_q   <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wb_we_q  <= wb_we_d;
      wb_rd_q  <= wb_rd_d;
      wb_din_q <= wb_din_d;
      st_q     <= st_d;
      dest_q   <= dest_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign wb_we     = wb_we_q;
  assign wb_rd     = wb_rd_q;
  assign wb_din    = wb_din_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized scoreboard bench for the load/store unit.
// Driver pushes expected outcomes; a negedge monitor pops on done.
module tb_lsu;

  localparam int TO = 15;

  typedef struct {
    bit         st;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [2:0] dest;
    logic [7:0] rdata;
    int         w;
  } exp_t;

  logic       clk = 0;
  logic       rst = 1;
  logic       run = 1;
  logic       start = 0;
  logic       is_store = 0;
  logic [7:0] base = 0;
  logic [7:0] offset = 0;
  logic [7:0] store_data = 0;
  logic [2:0] dest = 0;
  logic       busy, done, fault, mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_ack = 0;
  logic [7:0] mem_rdata = 0;
  logic       wb_we;
  logic [2:0] wb_rd;
  logic [7:0] wb_din;

  exp_t q[$];
  int   passed = 0;
  int   total = 0;
  bit   in_reset = 1;
  bit   stall_en = 0;
  bit   force_ack = 0;
  int   req_cnt = 0;
  int   wr_cnt = 0;
  bit   last_req = 0;
  logic [2:0] wr_rd = 0;
  logic [7:0] wr_din = 0;

  lsu #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .start      (start),
    .is_store   (is_store),
    .base       (base),
    .offset     (offset),
    .store_data (store_data),
    .dest       (dest),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_din     (wb_din)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
  endtask

  // monitor + bus responder: decides run for the coming edge, then checks
  always @(negedge clk) begin
    if (in_reset) begin
      run       = 1;
      mem_ack   = force_ack;
      mem_rdata = 0;
      req_cnt   = 0;
      wr_cnt    = 0;
      last_req  = 0;
    end else begin
      run = stall_en ? ($urandom % 4 != 0) : 1'b1;
      if (run && wb_we) begin
        wr_cnt++;
        wr_rd  = wb_rd;
        wr_din = wb_din;
      end
      if (mem_req) begin
        if (q.size() == 0) chk("req_orphan", q.size(), 1);
        else chk("bus_fields", {fault, mem_we, mem_addr, mem_wdata},
                 {1'b0, q[0].st, q[0].addr, q[0].wdata});
      end
      if (done && run) begin
        if (q.size() == 0) chk("done_orphan", q.size(), 1);
        else begin
          exp_t e;
          bit   to;
          int   nw;
          e  = q.pop_front();
          to = (e.w < 0);
          nw = (!e.st && !to && e.dest != 0) ? 1 : 0;
          chk("fault", fault, to);
          chk("req_cycles", req_cnt, to ? TO : e.w + 1);
          chk("done_after_req", last_req, 1);
          chk("wb_count", wr_cnt, nw);
          if (nw == 1) chk("wb_data", {wr_rd, wr_din}, {e.dest, e.rdata});
        end
        req_cnt = 0;
        wr_cnt  = 0;
      end
      mem_ack   = 0;
      mem_rdata = 8'($urandom);
      if (mem_req && q.size() > 0) begin
        if (run) begin
          if (q[0].w == req_cnt) begin
            mem_ack   = 1;
            mem_rdata = q[0].rdata;
          end
          req_cnt++;
        end else begin
          mem_ack = ($urandom % 2 == 1);
        end
      end else if (!mem_req) begin
        mem_ack = ($urandom % 4 == 0);
      end
      if (run) last_req = mem_req;
    end
  end

  task automatic issue(input bit st, input logic [7:0] b, input logic [7:0] o,
                       input logic [7:0] sd, input logic [2:0] d,
                       input logic [7:0] rd, input int w);
    bit   cap = 0;
    int   n = 0;
    exp_t e;
    while (!cap) begin
      @(negedge clk);
      if (!busy) begin
        start = 1; is_store = st; base = b; offset = o;
        store_data = sd; dest = d;
        @(posedge clk);
        if (run) cap = 1;
      end else begin
        start = ($urandom % 2 == 1);
        is_store = ($urandom % 2 == 1);
        base = 8'($urandom); offset = 8'($urandom);
        store_data = 8'($urandom); dest = 3'($urandom);
      end
      n++;
      if (n > 2000) begin
        $display("FAIL issue_timeout actual=%0d required<=2000", n);
        $fatal(1, "stuck");
      end
    end
    e.st    = st;
    e.addr  = 8'((int'(b) + int'(o)) % 256);
    e.wdata = sd;
    e.dest  = d;
    e.rdata = rd;
    e.w     = w;
    q.push_back(e);
  endtask

  function automatic int pick_wait();
    int sel;
    sel = $urandom % 8;
    if (sel < 5) return sel;
    if (sel == 5) return TO - 1;
    return -1;
  endfunction

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_state", {busy, done, fault, mem_req, mem_we, wb_we,
        mem_addr, mem_wdata, wb_rd, wb_din}, 0);
    rst = 0;
    @(posedge clk);
    in_reset = 0;
    issue(0, 8'h10, 8'h05, 8'h00, 3'd3, 8'hA7, 0);
    issue(1, 8'h05, 8'hFE, 8'h5C, 3'd6, 8'h11, 3);
    issue(0, 8'hF0, 8'h20, 8'h00, 3'd0, 8'h99, 1);
    issue(0, 8'h40, 8'h01, 8'h00, 3'd2, 8'h22, -1);
    issue(1, 8'h80, 8'h80, 8'h3C, 3'd1, 8'h00, 0);
    stall_en = 1;
    for (int i = 0; i < 60; i++) begin
      issue(($urandom % 2 == 1), 8'($urandom), 8'($urandom),
            8'($urandom), 3'($urandom), 8'($urandom), pick_wait());
    end
    @(negedge clk);
    start = 0;
    n = 0;
    while (q.size() > 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    stall_en = 0;
    @(posedge clk);
    in_reset = 1;
    @(negedge clk);
    start = 1; is_store = 0; base = 8'h33; offset = 8'h01;
    store_data = 8'hC3; dest = 3'd5;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    chk("pre_rst_req", {busy, mem_req, mem_addr}, {2'b11, 8'h34});
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_outs", {busy, done, fault, mem_req, mem_we, wb_we,
        mem_addr, mem_wdata, wb_rd, wb_din}, 0);
    @(posedge clk);
    force_ack = 1;
    @(posedge clk);
    @(negedge clk);
    force_ack = 0;
    chk("late_ack", {busy, done, fault, mem_req, wb_we}, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=%0t required<400000", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the 8-bit core. It sits between execute and the register file and sequences one memory access at a time over a req/ack bus. For loads, it produces the register-file write port signals (`wb_we`, `wb_rd`, `wb_din`). Address is computed from the `rs1` operand plus immediate, and store data comes from the `rs2` operand.

## Interface
- `BITS`, 8, data width.
- `RBITS`, 3, register index width.
- `ABITS`, 8, bus address width; must be ≥ `BITS`.
- `TIMEOUT`, 15, max cycles in ACCESS without `mem_ack` before fault; range 1..255.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  global enable; low freezes all state.
- `start`  in  1  execute presents a valid memory op this cycle.
- `is_store`  in  1  1 = store, 0 = load.
- `base`  in  `BITS`  `rs1` operand.
- `offset`  in  `BITS`  immediate, two's complement.
- `store_data`  in  `BITS`  `rs2` operand.
- `dest`  in  `RBITS`  load destination register.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.
- `fault`  out  1  last op timed out; sticky.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  bus write strobe, valid with `mem_req`.
- `mem_addr`  out  `ABITS`  bus address.
- `mem_wdata`  out  `BITS`  bus write data.
- `mem_ack`  in  1  bus completion, sampled only in ACCESS.
- `mem_rdata`  in  `BITS`  read data, valid with `mem_ack`.
- `wb_we`  out  1  register-file write enable.
- `wb_rd`  out  `RBITS`  register-file write index.
- `wb_din`  out  `BITS`  register-file write data.

## Operation
- States: IDLE, ACCESS, WB.
- **IDLE**
  - `start & run` captures the op:
    - `mem_addr` = zero-extend(`(base + offset) mod 2^BITS`).
    - `mem_wdata` = `store_data`, `mem_we` = `is_store`.
    - Internally latches `dest` and `is_store`.
  - Sets `mem_req` = 1, clears `fault`, clears the timeout counter, and goes to ACCESS.
- **ACCESS**
  - `mem_req` stays high; `addr`, `wdata` and `we` are held stable.
  - On `mem_ack & run`:
    - Deassert `mem_req` and `mem_we`.
    - Store: pulse `done`, go to IDLE.
    - Load: latch `mem_rdata` into `wb_din`, go to WB.
  - Otherwise the counter increments. When it reaches `TIMEOUT`:
    - Deassert `mem_req`, set `fault`, pulse `done`, go to IDLE.
    - No writeback occurs.
- **WB**
  - Drives `wb_we` = 1 for exactly one run cycle, with `wb_rd` = latched `dest`.
  - Pulses `done` and goes to IDLE.
  - If `dest` == 0, `wb_we` stays 0; `done` still pulses.
- Boundary rules:
  - `start` while `busy` is ignored; execute must hold off.
  - `mem_ack` outside ACCESS is ignored.
  - `mem_ack` in the same cycle the counter hits `TIMEOUT`: ack wins, no fault.
  - Address sum wraps modulo 2^`BITS` (e.g. 0xF0 + 0x20 → 0x10; 0x05 + 0xFE → 0x03).
  - `run` low: state, counter and all outputs hold, including `wb_we` in WB. The register file also gates writes with `run`, so the write lands on the first `run`-high cycle.
- `rst` (any state, including mid-access): next edge gives IDLE.
  - `busy`, `done`, `fault`, `mem_req`, `mem_we`, `wb_we` = 0.
  - `mem_addr`, `mem_wdata`, `wb_rd`, `wb_din` = 0; counter = 0.
  - The in-flight access is abandoned. The bus must tolerate `req` dropping.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Load with ack on first ACCESS cycle:
  - Cycle 0: `start` sampled.
  - Cycle 1: `mem_req` = 1 and `mem_ack` = 1.
  - Cycle 2: `wb_we` = 1, `done` = 1.
  - Cycle 3: IDLE, and a new `start` can be sampled.
- Store with ack on first ACCESS cycle: `done` in cycle 2; a new `start` can be sampled in cycle 2.
- Each extra wait cycle before ack adds one cycle.
- Timeout: `mem_req` is high for `TIMEOUT` cycles; `fault` and `done` appear the following cycle.
- `done` and `wb_we` are each high for exactly one cycle per op (excluding `run` stalls).

## Structure
- Shared package `lsu_pkg`:
  - State enum {IDLE, ACCESS, WB}.
  - Width constants `BITS`, `RBITS`, `ABITS` shared with `registers`.
- One sub-module, `lsu_timer`: loadable up-counter with clear, enable (`run & in_access`), and terminal-count output at `TIMEOUT`.
- FSM, address adder and output registers live in `lsu`.

## Test plan
- Load: `base`=0x10, `offset`=0x05, `dest`=3, ack on first ACCESS cycle with `mem_rdata`=0xA7 → `mem_addr`=0x15, `mem_we`=0, then `wb_we`=1, `wb_rd`=3, `wb_din`=0xA7, `done` in cycle 2.
- Store with wrap: `base`=0x05, `offset`=0xFE, `store_data`=0x5C, ack after 3 wait cycles → `mem_addr`=0x03, `mem_we`=1, `mem_wdata`=0x5C stable throughout; `done` 1 cycle after ack; `wb_we` never 1.
- Load to `dest`=0 → bus access occurs, `wb_we` stays 0, `done` pulses.
- Timeout: never ack, `TIMEOUT`=15 → `mem_req` high 15 cycles, then `fault`=1 and `done`=1, no writeback. Next `start` clears `fault`.
- Stall: drop `run` for 4 cycles during ACCESS and again in WB → `mem_req`, counter and `wb_we` hold; no double writeback; `start` pulses while `busy` are ignored.
- Reset mid-ACCESS (`mem_req`=1) → next edge: all outputs 0, IDLE; a late `mem_ack` is ignored.
